// File: rtl/cfg_bitstream_loader_if.sv
// Byte-wide configuration stream with a valid/ready handshake.
// A beat transfers on a rising clock edge where cfg_valid and cfg_ready are both high.
interface cfg_bitstream_loader_if #(
   parameter int unsigned IN_WIDTH = 8
);
   logic [IN_WIDTH-1:0] cfg_data;
   logic                cfg_valid;
   logic                cfg_ready;

   modport master (output cfg_data, output cfg_valid, input  cfg_ready);
   modport slave  (input  cfg_data, input  cfg_valid, output cfg_ready);
endinterface

// File: rtl/cfg_bitstream_loader.sv
// Frames a sync/data/XOR-checksum stream into a shadow word.
// The shadow is committed atomically to prog, with a one-cycle prog_en strobe.
module cfg_bitstream_loader #(
   parameter int unsigned          PROG_WIDTH = 4480,
   parameter int unsigned          IN_WIDTH   = 8,
   parameter logic [IN_WIDTH-1:0]  SYNC_WORD  = IN_WIDTH'(8'hA5)
) (
   input  logic                   clb_clk,
   input  logic                   rst_n,
   cfg_bitstream_loader_if.slave  cfg,
   output logic [PROG_WIDTH-1:0]  prog,
   output logic                   prog_en,
   output logic                   busy,
   output logic                   done,
   output logic                   error
);
   localparam int unsigned NBYTES = PROG_WIDTH / IN_WIDTH;
   localparam int unsigned CNT_W  = $clog2(NBYTES + 1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBYTES - 1);

   typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [IN_WIDTH-1:0]    acc_q, acc_d;
   logic [PROG_WIDTH-1:0]  shadow_q, shadow_d;
   logic [PROG_WIDTH-1:0]  prog_d;
   logic                   prog_en_d, busy_d, done_d, error_d;
   logic                   ready_q, ready_d;
   logic                   beat_c;

   assign cfg.cfg_ready = ready_q;
   assign beat_c        = cfg.cfg_valid & ready_q;

   // State and datapath registers; reset deconfigures the fabric
   always_ff @(posedge clb_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         shadow_q <= '0;
         prog     <= '0;
         prog_en  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         shadow_q <= shadow_d;
         prog     <= prog_d;
         prog_en  <= prog_en_d;
         busy     <= busy_d;
         done     <= done_d;
         error    <= error_d;
         ready_q  <= ready_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      shadow_d  = shadow_q;
      prog_d    = prog;
      prog_en_d = 1'b0;
      done_d    = done;
      error_d   = error;

      unique case (state_q)
         IDLE: begin
            if (beat_c && cfg.cfg_data == SYNC_WORD) begin
               state_d = LOAD;
               cnt_d   = '0;
               acc_d   = '0;
               done_d  = 1'b0;
               error_d = 1'b0;
            end
         end
         LOAD: begin
            // Sync bytes inside a frame are plain data; no resync
            if (beat_c) begin
               shadow_d = {shadow_q[PROG_WIDTH-IN_WIDTH-1:0], cfg.cfg_data};
               acc_d    = acc_q ^ cfg.cfg_data;
               cnt_d    = CNT_W'(cnt_q + CNT_W'(1));
               if (cnt_q == LAST_BEAT) begin
                  state_d = CHECK;
               end
            end
         end
         CHECK: begin
            if (beat_c) begin
               if (cfg.cfg_data == acc_q) begin
                  state_d = COMMIT;
               end else begin
                  error_d = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         COMMIT: begin
            prog_d    = shadow_q;
            prog_en_d = 1'b1;
            done_d    = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Registered status follows the state being entered
      ready_d = (state_d != COMMIT);
      busy_d  = (state_d != IDLE);
   end
endmodule
